// File: rtl/decode_unit.sv
// decode_unit: instruction decode stage. It holds the 32x32 register file with a
// write-before-read bypass, decodes the instruction into its fields, class flags
// and sign-extended immediate, detects load-use hazards, and registers the result
// into the ex_* outputs.
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   id_pc, id_inst        instruction in decode
//   id_do_not_execute     1 = the decode slot is a bubble
//   wb_we, wb_rd, wb_data register-file write port from writeback
//   stall_fetch           combinational; upstream holds id_* while 1
//   ex_*                  registered decoded instruction
//   illegal_inst          sticky, set on an unknown opcode
module decode_unit #(
  parameter int unsigned ADDR_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] id_pc,
  input  logic [31:0]       id_inst,
  input  logic              id_do_not_execute,
  input  logic              wb_we,
  input  logic [4:0]        wb_rd,
  input  logic [31:0]       wb_data,
  output logic              stall_fetch,
  output logic              ex_valid,
  output logic [ADDR_W-1:0] ex_pc,
  output logic [6:0]        ex_opcode,
  output logic [2:0]        ex_funct3,
  output logic [6:0]        ex_funct7,
  output logic [4:0]        ex_rd,
  output logic [31:0]       ex_rs1_val,
  output logic [31:0]       ex_rs2_val,
  output logic [31:0]       ex_imm,
  output logic              ex_is_load,
  output logic              ex_is_store,
  output logic              ex_is_branch,
  output logic              ex_is_jump,
  output logic              ex_reg_write,
  output logic              illegal_inst
);

  typedef enum logic [6:0] {
    OPC_LUI    = 7'b0110111,
    OPC_AUIPC  = 7'b0010111,
    OPC_JAL    = 7'b1101111,
    OPC_JALR   = 7'b1100111,
    OPC_BRANCH = 7'b1100011,
    OPC_STORE  = 7'b0100011,
    OPC_LOAD   = 7'b0000011,
    OPC_OPIMM  = 7'b0010011,
    OPC_OP     = 7'b0110011
  } opcode_e;

  typedef enum logic [2:0] {
    FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J
  } fmt_e;

  logic [31:0] regs_q [32];
  logic [31:0] regs_d [32];

  logic              ex_valid_q,  ex_valid_d;
  logic [ADDR_W-1:0] ex_pc_q,     ex_pc_d;
  logic [6:0]        ex_opcode_q, ex_opcode_d;
  logic [2:0]        ex_funct3_q, ex_funct3_d;
  logic [6:0]        ex_funct7_q, ex_funct7_d;
  logic [4:0]        ex_rd_q,     ex_rd_d;
  logic [31:0]       ex_rs1_q,    ex_rs1_d;
  logic [31:0]       ex_rs2_q,    ex_rs2_d;
  logic [31:0]       ex_imm_q,    ex_imm_d;
  logic              ex_load_q,   ex_load_d;
  logic              ex_store_q,  ex_store_d;
  logic              ex_branch_q, ex_branch_d;
  logic              ex_jump_q,   ex_jump_d;
  logic              ex_rw_q,     ex_rw_d;
  logic              illegal_q,   illegal_d;

  logic [4:0]  rs1, rs2, rd;
  logic        known, has_rd, uses_rs1, uses_rs2;
  logic        c_load, c_store, c_branch, c_jump;
  fmt_e        fmt;
  logic [31:0] imm;
  logic [31:0] rs1_val, rs2_val;
  logic        hazard, issue;

  assign rs1 = id_inst[19:15];
  assign rs2 = id_inst[24:20];
  assign rd  = id_inst[11:7];

  // Opcode classification.
  always_comb begin
    known    = 1'b1;
    has_rd   = 1'b0;
    uses_rs1 = 1'b1;
    uses_rs2 = 1'b0;
    c_load   = 1'b0;
    c_store  = 1'b0;
    c_branch = 1'b0;
    c_jump   = 1'b0;
    fmt      = FMT_R;
    case (id_inst[6:0])
      OPC_LUI, OPC_AUIPC: begin fmt = FMT_U; has_rd = 1'b1; uses_rs1 = 1'b0; end
      OPC_JAL:    begin fmt = FMT_J; has_rd = 1'b1; uses_rs1 = 1'b0; c_jump = 1'b1; end
      OPC_JALR:   begin fmt = FMT_I; has_rd = 1'b1; c_jump = 1'b1; end
      OPC_BRANCH: begin fmt = FMT_B; uses_rs2 = 1'b1; c_branch = 1'b1; end
      OPC_STORE:  begin fmt = FMT_S; uses_rs2 = 1'b1; c_store = 1'b1; end
      OPC_LOAD:   begin fmt = FMT_I; has_rd = 1'b1; c_load = 1'b1; end
      OPC_OPIMM:  begin fmt = FMT_I; has_rd = 1'b1; end
      OPC_OP:     begin fmt = FMT_R; has_rd = 1'b1; uses_rs2 = 1'b1; end
      default:    begin known = 1'b0; uses_rs1 = 1'b0; end
    endcase
  end

  always_comb begin
    case (fmt)
      FMT_I:   imm = {{20{id_inst[31]}}, id_inst[31:20]};
      FMT_S:   imm = {{20{id_inst[31]}}, id_inst[31:25], id_inst[11:7]};
      FMT_B:   imm = {{19{id_inst[31]}}, id_inst[31], id_inst[7], id_inst[30:25],
                      id_inst[11:8], 1'b0};
      FMT_U:   imm = {id_inst[31:12], 12'b0};
      FMT_J:   imm = {{11{id_inst[31]}}, id_inst[31], id_inst[19:12], id_inst[20],
                      id_inst[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

  // Register file: x0 never written; same-cycle writeback is forwarded to reads.
  always_comb begin
    regs_d = regs_q;
    if (wb_we && wb_rd != '0) regs_d[wb_rd] = wb_data;
  end

  always_comb begin
    if (rs1 == '0)                       rs1_val = '0;
    else if (wb_we && wb_rd == rs1)      rs1_val = wb_data;
    else                                 rs1_val = regs_q[rs1];
    if (rs2 == '0)                       rs2_val = '0;
    else if (wb_we && wb_rd == rs2)      rs2_val = wb_data;
    else                                 rs2_val = regs_q[rs2];
  end

  // Load-use hazard against the instruction currently held in ex_*. A bubble in
  // ex clears ex_is_load, so every such stall is exactly one cycle long.
  always_comb begin
    hazard = ex_valid_q && ex_load_q && (ex_rd_q != '0) && !id_do_not_execute && known &&
             ((uses_rs1 && rs1 == ex_rd_q) || (uses_rs2 && rs2 == ex_rd_q));
    issue  = !id_do_not_execute && known && !hazard;
  end

  assign stall_fetch = hazard && !reset;

  always_comb begin
    ex_valid_d  = issue;
    ex_pc_d     = id_pc;
    ex_opcode_d = id_inst[6:0];
    ex_funct3_d = id_inst[14:12];
    ex_funct7_d = id_inst[31:25];
    ex_rd_d     = (issue && has_rd) ? rd : '0;
    ex_rs1_d    = rs1_val;
    ex_rs2_d    = rs2_val;
    ex_imm_d    = imm;
    ex_load_d   = issue && c_load;
    ex_store_d  = issue && c_store;
    ex_branch_d = issue && c_branch;
    ex_jump_d   = issue && c_jump;
    ex_rw_d     = issue && has_rd && (rd != '0);
    illegal_d   = illegal_q || (!id_do_not_execute && !known);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < 32; i++) regs_q[i] <= '0;
      ex_valid_q  <= 1'b0;
      ex_pc_q     <= '0;
      ex_opcode_q <= '0;
      ex_funct3_q <= '0;
      ex_funct7_q <= '0;
      ex_rd_q     <= '0;
      ex_rs1_q    <= '0;
      ex_rs2_q    <= '0;
      ex_imm_q    <= '0;
      ex_load_q   <= 1'b0;
      ex_store_q  <= 1'b0;
      ex_branch_q <= 1'b0;
      ex_jump_q   <= 1'b0;
      ex_rw_q     <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      regs_q      <= regs_d;
      ex_valid_q  <= ex_valid_d;
      ex_pc_q     <= ex_pc_d;
      ex_opcode_q <= ex_opcode_d;
      ex_funct3_q <= ex_funct3_d;
      ex_funct7_q <= ex_funct7_d;
      ex_rd_q     <= ex_rd_d;
      ex_rs1_q    <= ex_rs1_d;
      ex_rs2_q    <= ex_rs2_d;
      ex_imm_q    <= ex_imm_d;
      ex_load_q   <= ex_load_d;
      ex_store_q  <= ex_store_d;
      ex_branch_q <= ex_branch_d;
      ex_jump_q   <= ex_jump_d;
      ex_rw_q     <= ex_rw_d;
      illegal_q   <= illegal_d;
    end
  end

  assign ex_valid     = ex_valid_q;
  assign ex_pc        = ex_pc_q;
  assign ex_opcode    = ex_opcode_q;
  assign ex_funct3    = ex_funct3_q;
  assign ex_funct7    = ex_funct7_q;
  assign ex_rd        = ex_rd_q;
  assign ex_rs1_val   = ex_rs1_q;
  assign ex_rs2_val   = ex_rs2_q;
  assign ex_imm       = ex_imm_q;
  assign ex_is_load   = ex_load_q;
  assign ex_is_store  = ex_store_q;
  assign ex_is_branch = ex_branch_q;
  assign ex_is_jump   = ex_jump_q;
  assign ex_reg_write = ex_rw_q;
  assign illegal_inst = illegal_q;

endmodule

// File: doc/decode_unit.md
DECODE_UNIT -- requirements
Module: decode_unit

Interface
REQ-001 Parameter: ADDR_W, default 16, width of the PC field.
REQ-002 The block SHALL have one clock and a synchronous, active-high reset.
REQ-003 Port: clk  in  1  rising-edge clock.
REQ-004 Port: reset  in  1  synchronous, active-high reset.
REQ-005 Port: id_pc  in  ADDR_W  PC of the instruction in decode.
REQ-006 Port: id_inst  in  32  instruction word in decode.
REQ-007 Port: id_do_not_execute  in  1  1 = slot is a bubble.
REQ-008 Port: wb_we, wb_rd, wb_data  in  1/5/32  register-file write port from writeback.
REQ-009 Port: stall_fetch  out  1  combinational; upstream SHALL hold id_* for the next cycle while it is 1.
REQ-010 Port: ex_valid, ex_pc, ex_opcode[6:0], ex_funct3[2:0], ex_funct7[6:0], ex_rd[4:0]  out  registered decoded fields.
REQ-011 Port: ex_rs1_val, ex_rs2_val, ex_imm  out  32 each  registered operands and sign-extended immediate.
REQ-012 Port: ex_is_load, ex_is_store, ex_is_branch, ex_is_jump, ex_reg_write  out  1 each  registered class flags.
REQ-013 Port: illegal_inst  out  1  sticky flag, set on an unknown opcode.

Function
REQ-014 The block SHALL contain a 32x32 register file; x0 SHALL read as 0 and writes to x0 SHALL be ignored.
REQ-015 On wb_we with wb_rd equal to rs1/rs2 (id_inst[19:15]/[24:20], nonzero) in the same cycle, the read SHALL return wb_data (write-before-read bypass).
REQ-016 Recognised opcodes:
- LUI 0110111, AUIPC 0010111 (U-type)
- JAL 1101111 (J-type), JALR 1100111 (I-type)
- BRANCH 1100011 (B-type), STORE 0100011 (S-type)
- LOAD 0000011, OP-IMM 0010011 (I-type)
- OP 0110011 (imm = 0)
REQ-017 Immediates SHALL be sign-extended from inst[31]; B and J immediates SHALL have bit 0 = 0; the U immediate SHALL be {inst[31:12], 12'b0}.
REQ-018 ex_reg_write SHALL be 1 for LUI, AUIPC, JAL, JALR, LOAD, OP-IMM and OP when rd != 0, and 0 otherwise.
REQ-019 The ex_* outputs SHALL be registered with one-cycle latency; input captured at edge N appears after edge N.
REQ-020 Bubble cycle: ex_valid=0, all class flags=0, ex_rd=0; ex_pc, operands and immediate are don't-care.
REQ-021 A bubble SHALL be issued when any of the following holds:
- id_do_not_execute=1;
- the opcode is unknown, which also SHALL set illegal_inst;
- a load-use hazard is present.
REQ-022 Load-use hazard definition:
- registered ex_valid & ex_is_load & ex_rd != 0;
- ex_rd equals a source register that the current instruction reads (rs1 for all types except U/J; rs2 for BRANCH/STORE/OP);
- current slot valid with a known opcode.
REQ-023 During a hazard, stall_fetch=1 in that same cycle, and the next edge SHALL issue a bubble.
REQ-024 After the bubble, ex_is_load=0, so the held instruction SHALL issue at the following edge; each load-use stall SHALL last exactly one cycle.
REQ-025 stall_fetch SHALL be 0 whenever id_do_not_execute=1.
REQ-026 illegal_inst SHALL remain 1 until reset.

Reset
REQ-027 While reset=1 at an edge, the block SHALL clear:
- ex_valid and all class flags;
- ex_pc, ex_opcode, ex_funct3, ex_funct7, ex_rd, ex_rs1_val, ex_rs2_val, ex_imm;
- illegal_inst and all 32 registers.
REQ-028 stall_fetch SHALL be 0 while reset=1.
REQ-029 Reset asserted mid-stall SHALL discard the pending hazard; the first instruction after reset SHALL issue without a bubble.
REQ-030 wb_we SHALL be ignored in any cycle in which reset=1.

Verification
REQ-031 Scenario, bypass: write x5=0x1234 via wb in the same cycle as decoding ADD x6,x5,x0 -> next cycle ex_rs1_val=0x1234, ex_reg_write=1, ex_rd=6.
REQ-032 Scenario, immediates:
- BEQ with imm=-4 (0xFE000EE3) -> ex_imm=0xFFFFFFFC, ex_is_branch=1;
- LUI x1,0xABCDE -> ex_imm=0xABCDE000.
REQ-033 Scenario, load-use: LW x3,0(x0) then ADD x4,x3,x3 -> stall_fetch=1 for one cycle, one bubble (ex_valid=0), then ADD issues; JAL x1 after LW x1 -> no stall.
REQ-034 Scenario, bubble: id_do_not_execute=1 with a valid-looking LW x7 -> ex_valid=0, ex_is_load=0, stall_fetch=0, and no stall on the next instruction.
REQ-035 Scenario, illegal: opcode 1111111 -> ex_valid=0 and illegal_inst=1; it stays 1 across 10 valid instructions and clears only on reset.
REQ-036 Scenario, x0 and reset: wb write of x0=0xFFFFFFFF -> reads of x0 return 0; reset during a load-use stall -> all outputs 0 next cycle, stall_fetch=0.
